// File: rtl/block_transfer_seq_if.sv
// Memory bus and register-file port bundle for the block transfer sequencer.
// master = the sequencer, slave = the memory/register-file side.
interface block_transfer_seq_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [3:0]  rf_read_addr;
  logic [31:0] rf_read_data;
  logic [3:0]  rf_write_addr;
  logic [31:0] rf_write_data;
  logic        rf_reg_write;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata,
    output rf_read_addr, rf_write_addr, rf_write_data, rf_reg_write,
    input  rf_read_data
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata,
    input  rf_read_addr, rf_write_addr, rf_write_data, rf_reg_write,
    output rf_read_data
  );
endinterface

// File: rtl/block_transfer_seq.sv
// Load/store-multiple sequencer: walks a 16-bit register list lowest-first,
// one memory access per register, with optional base register writeback.
module block_transfer_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        load,
  input  logic [15:0] reg_list,
  input  logic [31:0] base_addr,
  input  logic [3:0]  base_reg,
  input  logic        writeback,
  output logic        busy,
  output logic        done,
  block_transfer_seq_if.master bus
);

  typedef enum logic [2:0] {IDLE, SCAN, MEM, LOAD_WR, WB_BASE, DONE} state_t;

  state_t      state, state_d, pick;
  logic        load_q, wb_q, supp_q;
  logic [15:0] list_q, list_clr, sel_list;
  logic [3:0]  base_reg_q, idx_q, lsb;
  logic [31:0] base_q, addr_q, rdata_q;
  logic [4:0]  count_q;

  always_comb begin
    lsb = '0;
    for (int unsigned i = 16; i > 0; i--)
      if (list_q[i-1]) lsb = 4'(i - 1);
  end

  assign list_clr = list_q & ~(16'd1 << idx_q);

  // In MEM the selection must see the list with the current bit already cleared.
  always_comb begin
    sel_list = (state == MEM) ? list_clr : list_q;
    if (|sel_list)             pick = SCAN;
    else if (wb_q && !supp_q)  pick = WB_BASE;
    else                       pick = DONE;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (start) state_d = SCAN;
      SCAN:    state_d = (list_q == '0) ? DONE : MEM;
      MEM:     if (bus.mem_ack) state_d = load_q ? LOAD_WR : pick;
      LOAD_WR: state_d = pick;
      WB_BASE: state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      load_q     <= 1'b0;
      wb_q       <= 1'b0;
      supp_q     <= 1'b0;
      list_q     <= '0;
      base_reg_q <= '0;
      idx_q      <= '0;
      base_q     <= '0;
      addr_q     <= '0;
      rdata_q    <= '0;
      count_q    <= '0;
    end else begin
      state <= state_d;
      case (state)
        IDLE: if (start) begin
          load_q     <= load;
          list_q     <= reg_list;
          base_reg_q <= base_reg;
          wb_q       <= writeback;
          supp_q     <= load & reg_list[base_reg];
          base_q     <= base_addr & 32'hFFFF_FFFC;
          addr_q     <= base_addr & 32'hFFFF_FFFC;
          count_q    <= '0;
        end
        SCAN: idx_q <= lsb;
        MEM: if (bus.mem_ack) begin
          list_q  <= list_clr;
          addr_q  <= addr_q + 32'd4;
          count_q <= count_q + 5'd1;
          rdata_q <= bus.mem_rdata;
        end
        default: ;
      endcase
    end
  end

  // Strobes are masked by rst so nothing is issued during the reset cycle itself.
  always_comb begin
    busy              = (state != IDLE);
    done              = 1'b0;
    bus.mem_req       = 1'b0;
    bus.mem_we        = 1'b0;
    bus.mem_addr      = '0;
    bus.mem_wdata     = '0;
    bus.rf_read_addr  = '0;
    bus.rf_write_addr = '0;
    bus.rf_write_data = '0;
    bus.rf_reg_write  = 1'b0;
    case (state)
      SCAN: bus.rf_read_addr = lsb;
      MEM: begin
        bus.mem_req      = ~rst;
        bus.mem_we       = ~load_q & ~rst;
        bus.mem_addr     = addr_q;
        bus.mem_wdata    = bus.rf_read_data;
        bus.rf_read_addr = idx_q;
      end
      LOAD_WR: begin
        bus.rf_reg_write  = ~rst;
        bus.rf_write_addr = idx_q;
        bus.rf_write_data = rdata_q;
      end
      WB_BASE: begin
        bus.rf_reg_write  = ~rst;
        bus.rf_write_addr = base_reg_q;
        bus.rf_write_data = base_q + {25'd0, count_q, 2'b00};
      end
      DONE: done = ~rst;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_block_transfer_seq.sv
// Bench for block_transfer_seq: transaction-level model predicts the memory
// accesses and register writes; a negedge process checks the DUT against it.
module tb_block_transfer_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        load = 1'b0;
  logic [15:0] reg_list = '0;
  logic [31:0] base_addr = '0;
  logic [3:0]  base_reg = '0;
  logic        writeback = 1'b0;
  logic        busy, done;

  block_transfer_seq_if bus();

  block_transfer_seq dut (
    .clk(clk), .rst(rst), .start(start), .load(load), .reg_list(reg_list),
    .base_addr(base_addr), .base_reg(base_reg), .writeback(writeback),
    .busy(busy), .done(done), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct { logic we; logic [31:0] addr; logic [31:0] data; } macc_t;
  typedef struct { logic [3:0] a; logic [31:0] d; } rfw_t;

  logic [31:0] rf [16];
  logic [31:0] memm [logic [31:0]];
  macc_t exp_m[$];
  rfw_t  exp_r[$];

  int total = 0;
  int bad = 0;
  int unsigned ack_delay = 0;
  int unsigned wcnt = 0;
  logic spur = 1'b0;
  int unsigned done_cnt, rfw_count, mreq_cycles, first_len;
  logic first_acked, prev_done = 1'b0;
  int unsigned lat;

  assign bus.rf_read_data = rf[bus.rf_read_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rd_mem(input logic [31:0] a);
    return memm.exists(a) ? memm[a] : 32'h0;
  endfunction

  // Memory side: ack after ack_delay wait cycles; optional stray ack while not requested.
  always @(posedge clk) begin
    #2;
    if (bus.mem_req) begin
      if (wcnt == ack_delay) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = rd_mem(bus.mem_addr);
      end else begin
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'hDEAD_BEEF;
      end
      wcnt++;
    end else begin
      wcnt          = 0;
      bus.mem_ack   = spur;
      bus.mem_rdata = 32'hBAD0_0000;
    end
  end

  // Transaction model: every listed register in ascending order, consecutive words.
  task automatic predict(input logic ld, input logic [15:0] lst, input logic [31:0] base,
                         input logic [3:0] br, input logic wb);
    logic [31:0] a;
    int unsigned n;
    a = {base[31:2], 2'b00};
    n = 0;
    for (int i = 0; i < 16; i++) begin
      if (lst[i]) begin
        macc_t m;
        rfw_t  r;
        m.we   = !ld;
        m.addr = a + 32'(4 * n);
        m.data = ld ? 32'h0 : rf[i];
        exp_m.push_back(m);
        if (ld) begin
          r.a = 4'(i);
          r.d = rd_mem(m.addr);
          exp_r.push_back(r);
        end
        n++;
      end
    end
    if (n > 0 && wb && !(ld && lst[br])) begin
      rfw_t r;
      r.a = br;
      r.d = a + 32'(4 * n);
      exp_r.push_back(r);
    end
  endtask

  always @(negedge clk) begin
    macc_t m;
    rfw_t  r;
    if (rst) begin
      chk("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
      chk("rst_rf_write", {31'd0, bus.rf_reg_write}, 32'd0);
    end else begin
      if (bus.mem_req) begin
        mreq_cycles++;
        if (!first_acked) first_len++;
        chk("busy_in_mem", {31'd0, busy}, 32'd1);
        if (exp_m.size() == 0) begin
          chk("unexpected_mem_req", {31'd0, bus.mem_req}, 32'd0);
        end else begin
          m = exp_m[0];
          chk("mem_we", {31'd0, bus.mem_we}, {31'd0, m.we});
          chk("mem_addr", bus.mem_addr, m.addr);
          if (m.we) chk("mem_wdata", bus.mem_wdata, m.data);
          if (bus.mem_ack) begin
            if (bus.mem_we) memm[bus.mem_addr] = bus.mem_wdata;
            first_acked = 1'b1;
            void'(exp_m.pop_front());
          end
        end
      end
      if (bus.rf_reg_write) begin
        rfw_count++;
        if (exp_r.size() == 0) begin
          chk("unexpected_rf_write", {31'd0, bus.rf_reg_write}, 32'd0);
        end else begin
          r = exp_r[0];
          chk("rf_write_addr", {28'd0, bus.rf_write_addr}, {28'd0, r.a});
          chk("rf_write_data", bus.rf_write_data, r.d);
          void'(exp_r.pop_front());
        end
        rf[bus.rf_write_addr] = bus.rf_write_data;
      end
      if (done) begin
        done_cnt++;
        chk("done_after_all", 32'(exp_m.size() + exp_r.size()), 32'd0);
        chk("done_single", {31'd0, prev_done}, 32'd0);
      end
    end
    prev_done = done;
  end

  task automatic run(input logic ld, input logic [15:0] lst, input logic [31:0] base,
                     input logic [3:0] br, input logic wb, input int unsigned dly,
                     input int unsigned poke, output int unsigned latency);
    ack_delay   = dly;
    done_cnt    = 0;
    rfw_count   = 0;
    mreq_cycles = 0;
    first_len   = 0;
    first_acked = 1'b0;
    predict(ld, lst, base, br, wb);
    @(posedge clk); #1;
    load = ld; reg_list = lst; base_addr = base; base_reg = br; writeback = wb;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    latency = 0;
    while (done_cnt == 0 && latency < 300) begin
      @(negedge clk); #1;
      latency++;
      if (poke != 0 && latency == poke) begin
        start = 1'b1; reg_list = 16'hFFFF; load = ~ld;
      end else if (poke != 0 && latency == poke + 1) begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    if (done_cnt == 0) chk("done_timeout", 32'(latency), 32'd0);
    @(posedge clk); #1;
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_done", {31'd0, done}, 32'd0);
    chk("done_count", 32'(done_cnt), 32'd1);
    chk("queues_drained", 32'(exp_m.size() + exp_r.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) rf[i] = 32'h1000_0000 | 32'(i);
    memm[32'h200] = 32'h0000_0011;
    memm[32'h204] = 32'h0000_0022;
    memm[32'h300] = 32'h5555_AAAA;
    memm[32'h304] = 32'h0BAD_F00D;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_mem_req", {31'd0, bus.mem_req}, 32'd0);
    chk("reset_mem_we", {31'd0, bus.mem_we}, 32'd0);
    chk("reset_mem_addr", bus.mem_addr, 32'd0);
    chk("reset_mem_wdata", bus.mem_wdata, 32'd0);
    chk("reset_rf_read_addr", {28'd0, bus.rf_read_addr}, 32'd0);
    chk("reset_rf_write_addr", {28'd0, bus.rf_write_addr}, 32'd0);
    chk("reset_rf_write_data", bus.rf_write_data, 32'd0);
    #1 rst = 1'b0;

    // STM r1,r3 @0x100 with base writeback to r13
    run(1'b0, 16'h000A, 32'h100, 4'd13, 1'b1, 0, 0, lat);
    chk("stm_latency", 32'(lat), 32'd6);
    chk("stm_mem100", rd_mem(32'h100), 32'h1000_0001);
    chk("stm_mem104", rd_mem(32'h104), 32'h1000_0003);
    chk("stm_r13", rf[13], 32'h108);

    // LDM r0,r15 from 0x200, no writeback
    run(1'b1, 16'h8001, 32'h200, 4'd2, 1'b0, 0, 0, lat);
    chk("ldm_r0", rf[0], 32'h11);
    chk("ldm_r15", rf[15], 32'h22);
    chk("ldm_rf_writes", 32'(rfw_count), 32'd2);

    // LDM including the base register: loaded value wins, no WB_BASE
    run(1'b1, 16'h0020, 32'h300, 4'd5, 1'b1, 0, 0, lat);
    chk("ldm_base_r5", rf[5], 32'h5555_AAAA);
    chk("ldm_base_writes", 32'(rfw_count), 32'd1);

    // Empty list with stray acks present
    spur = 1'b1;
    run(1'b0, 16'h0000, 32'h500, 4'd7, 1'b1, 0, 0, lat);
    spur = 1'b0;
    chk("empty_latency", 32'(lat), 32'd2);
    chk("empty_mem_req", 32'(mreq_cycles), 32'd0);
    chk("empty_rf_writes", 32'(rfw_count), 32'd0);
    chk("empty_r7", rf[7], 32'h1000_0007);

    // STM with 3 wait cycles, address wrap, misaligned base, start poked mid-transfer
    run(1'b0, 16'h0006, 32'hFFFF_FFFE, 4'd3, 1'b1, 3, 3, lat);
    chk("wait_first_len", 32'(first_len), 32'd4);
    chk("wrap_memFFFC", rd_mem(32'hFFFF_FFFC), 32'h1000_0001);
    chk("wrap_mem0", rd_mem(32'h0), 32'h1000_0002);
    chk("wrap_r3", rf[3], 32'h4);
    chk("wait_latency", 32'(lat), 32'd12);

    // Reset while waiting in MEM
    ack_delay = 1000;
    predict(1'b0, 16'h0003, 32'h400, 4'd9, 1'b1);
    @(posedge clk); #1;
    load = 1'b0; reg_list = 16'h0003; base_addr = 32'h400; base_reg = 4'd9; writeback = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (!bus.mem_req && lat < 10) begin
      @(negedge clk); #1;
      lat++;
    end
    chk("rst_reached_mem", {31'd0, bus.mem_req}, 32'd1);
    rst = 1'b1;
    exp_m.delete();
    exp_r.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_mem_req", {31'd0, bus.mem_req}, 32'd0);
    @(negedge clk);
    chk("rst_mid_no_store", {31'd0, memm.exists(32'h400)}, 32'd0);
    chk("rst_mid_r9", rf[9], 32'h1000_0009);

    // Normal transfer after the aborted one
    run(1'b1, 16'h0003, 32'h300, 4'd8, 1'b1, 1, 0, lat);
    chk("post_rst_r0", rf[0], 32'h5555_AAAA);
    chk("post_rst_r1", rf[1], 32'h0BAD_F00D);
    chk("post_rst_r8", rf[8], 32'h308);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/block_transfer_seq.md
BLOCK_TRANSFER_SEQ -- requirements
Module: block_transfer_seq

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state changes on rising edge.
REQ-002 SHALL have: rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have: start  in  1  begin transfer, sampled only in IDLE.
REQ-004 SHALL have: load  in  1  1 = memory-to-registers (LDM), 0 = registers-to-memory (STM).
REQ-005 SHALL have: reg_list  in  16  bit i set = transfer register i.
REQ-006 SHALL have: base_addr  in  32  start byte address; base_reg  in  4  base register index; writeback  in  1  update base register at end.
REQ-007 SHALL have: mem_ack  in  1  memory completes current access; mem_rdata  in  32  load data, valid with mem_ack.
REQ-008 SHALL have: rf_read_data  in  32  register file read port, combinational from rf_read_addr.
REQ-009 SHALL have: busy  out  1;  done  out  1  one-cycle completion pulse.
REQ-010 SHALL have: rf_read_addr  out  4;  rf_write_addr  out  4;  rf_write_data  out  32;  rf_reg_write  out  1.
REQ-011 SHALL have: mem_req  out  1;  mem_we  out  1;  mem_addr  out  32;  mem_wdata  out  32.

Function
REQ-012 SHALL implement states IDLE, SCAN, MEM, LOAD_WR, WB_BASE, DONE.
REQ-013 IDLE with start=1 SHALL latch load, reg_list, base_reg, writeback, addr = {base_addr[31:2],2'b00}, count=0; next SCAN; start while not IDLE SHALL be ignored.
REQ-014 Empty latched list SHALL go SCAN -> DONE with no memory access and no base writeback.
REQ-015 SCAN (1 cycle) SHALL select idx = lowest set bit of remaining list, drive rf_read_addr=idx, next MEM.
REQ-016 MEM SHALL assert mem_req=1, mem_we=~load, mem_addr=addr, mem_wdata=rf_read_data (rf_read_addr held at idx), until mem_ack; outputs stable while waiting.
REQ-017 On mem_ack: clear bit idx, addr += 4, count += 1; load=1 -> LOAD_WR with captured mem_rdata; load=0 -> next-state selection (REQ-019).
REQ-018 LOAD_WR (1 cycle) SHALL drive rf_reg_write=1, rf_write_addr=idx, rf_write_data=captured data; then next-state selection; idx=15 written normally (register file redirects to PC).
REQ-019 Next-state selection: remaining list nonzero -> SCAN; else writeback=1 and base writeback not suppressed -> WB_BASE; else DONE.
REQ-020 Base writeback SHALL be suppressed when load=1 and reg_list bit base_reg set (loaded value wins).
REQ-021 WB_BASE (1 cycle) SHALL drive rf_reg_write=1, rf_write_addr=base_reg, rf_write_data = latched base_addr(aligned) + 4*count, then DONE.
REQ-022 DONE SHALL pulse done=1 for exactly one cycle, then IDLE.
REQ-023 busy SHALL be 1 in every state except IDLE; rf_reg_write SHALL be 1 only in LOAD_WR and WB_BASE; mem_req only in MEM.
REQ-024 Address arithmetic SHALL be modulo 2^32 (wrap from 0xFFFFFFFC to 0x00000000 without error).
REQ-025 mem_ack outside MEM SHALL be ignored.

Reset
REQ-026 rst=1 SHALL force IDLE next edge, overriding all activity including mid-transfer; no register write or memory request issued in or after the reset cycle.
REQ-027 Reset values: busy, done, mem_req, mem_we, rf_reg_write = 0; all address/data outputs = 0; internal list, count, addr = 0.

Verification
REQ-028 STM, list=0x000A, base=0x100, writeback=1, base_reg=13, ack immediate -> writes r1 @0x100, r3 @0x104; r13 <= 0x108; done one cycle after WB_BASE.
REQ-029 LDM, list=0x8001, base=0x200, mem_rdata 0x11/0x22 -> r0=0x11, r15=0x22 (pc_write path), rf_reg_write pulses exactly twice, no base write (writeback=0).
REQ-030 LDM, list=0x0020, base_reg=5, writeback=1 -> r5 = loaded value, WB_BASE skipped.
REQ-031 list=0x0000, start -> done after SCAN, mem_req never asserted.
REQ-032 STM with mem_ack delayed 3 cycles -> mem_req/addr/wdata held constant 4 cycles; base=0xFFFFFFFC, 2 regs -> second address 0x00000000.
REQ-033 rst asserted while in MEM -> next cycle busy=0, mem_req=0, no register write; new start then runs normally.
